// File: rtl/icap_reboot_sequencer.sv
// Replays the Spartan-3AN multiboot IPROG stream into ICAP_SPARTAN3A once TRIGGER is held.
// Define ICAP_GOLDEN_FALLBACK_EN to also program GENERAL3/4 with the golden image address.
module icap_reboot_sequencer #(
  parameter logic [23:0] BOOT_ADDR   = 24'h040000,
  parameter logic [7:0]  READ_OPCODE = 8'h0B,
  parameter logic [23:0] GOLDEN_ADDR = 24'h000000,
  parameter int          ARM_DELAY   = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        TRIGGER,
  input  logic        ICAP_BUSY,
  output logic        ICAP_CE_N,
  output logic        ICAP_WRITE_N,
  output logic [15:0] ICAP_I,
  output logic        BUSY,
  output logic        DONE
);

`ifdef ICAP_GOLDEN_FALLBACK_EN
  localparam int NWORDS = 13;
`else
  localparam int NWORDS = 9;
`endif
  localparam int IDXW = $clog2(NWORDS);
  localparam int CNTW = $clog2(ARM_DELAY + 1);
  localparam logic [IDXW-1:0] LAST = IDXW'(NWORDS - 1);

  typedef enum logic [2:0] {IDLE, ARM, SETUP, SEND, FLUSH, FIN} state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            trg_meta_q, trg_s_q;
  logic            ce_n_q, ce_n_d, wr_n_q, wr_n_d, busy_q, busy_d, done_q, done_d;
  logic [15:0]     data_q, data_d;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = b[7-k];
    return r;
  endfunction

  // ICAP expects each byte MSB-first on the opposite bit order
  function automatic logic [15:0] swap(input logic [15:0] w);
    return {rev8(w[15:8]), rev8(w[7:0])};
  endfunction

  function automatic logic [15:0] stream_word(input logic [IDXW-1:0] i);
    logic [15:0] w;
    case (int'(i))
      0:       w = 16'hFFFF;
      1:       w = 16'hAA99;
      2:       w = 16'h3261;
      3:       w = BOOT_ADDR[15:0];
      4:       w = 16'h3281;
      5:       w = {READ_OPCODE, BOOT_ADDR[23:16]};
`ifdef ICAP_GOLDEN_FALLBACK_EN
      6:       w = 16'h32A1;
      7:       w = GOLDEN_ADDR[15:0];
      8:       w = 16'h32C1;
      9:       w = {READ_OPCODE, GOLDEN_ADDR[23:16]};
      10:      w = 16'h30A1;
      11:      w = 16'h000E;
      12:      w = 16'h2000;
`else
      6:       w = 16'h30A1;
      7:       w = 16'h000E;
      8:       w = 16'h2000;
`endif
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      trg_meta_q <= 1'b0;
      trg_s_q    <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      ce_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      trg_meta_q <= TRIGGER;
      trg_s_q    <= trg_meta_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      ce_n_q     <= ce_n_d;
      wr_n_q     <= wr_n_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // The IDLE cycle that sees TRG_S high counts as the first of the ARM_DELAY cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    ce_n_d  = ce_n_q;
    wr_n_d  = wr_n_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = done_q;
    case (state_q)
      IDLE: if (trg_s_q) begin
        busy_d = 1'b1;
        if (ARM_DELAY <= 1) begin
          state_d = SETUP;
          wr_n_d  = 1'b0;
          idx_d   = '0;
          data_d  = swap(stream_word('0));
        end else begin
          state_d = ARM;
          cnt_d   = CNTW'(1);
        end
      end
      ARM: begin
        if (!trg_s_q) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else if (cnt_q == CNTW'(ARM_DELAY - 1)) begin
          state_d = SETUP;
          cnt_d   = '0;
          wr_n_d  = 1'b0;
          idx_d   = '0;
          data_d  = swap(stream_word('0));
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SETUP: begin
        state_d = SEND;
        ce_n_d  = 1'b0;
      end
      SEND: if (!ICAP_BUSY) begin
        if (idx_q == LAST) begin
          state_d = FLUSH;
          ce_n_d  = 1'b1;
        end else begin
          idx_d  = idx_q + 1'b1;
          data_d = swap(stream_word(idx_q + 1'b1));
        end
      end
      FLUSH: begin
        state_d = FIN;
        wr_n_d  = 1'b1;
        data_d  = '0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      FIN:     ;
      default: state_d = IDLE;
    endcase
  end

  assign ICAP_CE_N    = ce_n_q;
  assign ICAP_WRITE_N = wr_n_q;
  assign ICAP_I       = data_q;
  assign BUSY         = busy_q;
  assign DONE         = done_q;

endmodule

// File: tb/tb_icap_reboot_sequencer.sv
// Directed bench for icap_reboot_sequencer: stream table, arm latency, ICAP_BUSY stall,
// mid-stream reset and terminal DONE behaviour.
module tb_icap_reboot_sequencer;
  localparam int AD = 16;
`ifdef ICAP_GOLDEN_FALLBACK_EN
  localparam int NW = 13;
`else
  localparam int NW = 9;
`endif

  logic        CLK = 1'b0, RST_N = 1'b0, TRIGGER = 1'b0, ICAP_BUSY = 1'b0;
  logic        ICAP_CE_N, ICAP_WRITE_N, BUSY, DONE;
  logic [15:0] ICAP_I;

  always #5 CLK = ~CLK;

  icap_reboot_sequencer #(
    .BOOT_ADDR(24'h040000), .READ_OPCODE(8'h0B), .GOLDEN_ADDR(24'h010000), .ARM_DELAY(AD)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .TRIGGER(TRIGGER), .ICAP_BUSY(ICAP_BUSY),
    .ICAP_CE_N(ICAP_CE_N), .ICAP_WRITE_N(ICAP_WRITE_N), .ICAP_I(ICAP_I),
    .BUSY(BUSY), .DONE(DONE)
  );

  typedef struct {
    int          busy_cyc;
    logic [15:0] exp;
  } vec_t;

  vec_t vec[NW];
  int   total = 0, passed = 0, cap_total = 0;

  // Words actually accepted by the ICAP primitive
  always @(posedge CLK)
    if (RST_N && !ICAP_CE_N && !ICAP_WRITE_N && !ICAP_BUSY) cap_total++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  task automatic tick;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic wait_ce(output int edges);
    edges = 0;
    do begin
      tick;
      edges++;
    end while (ICAP_CE_N && edges < 200);
  endtask

  task automatic do_reset;
    RST_N = 1'b0;
    TRIGGER = 1'b0;
    ICAP_BUSY = 1'b0;
    tick;
    RST_N = 1'b1;
    tick;
  endtask

  // Entered at the negedge where word 0 is first presented with CE_N low.
  task automatic run_stream(input bit use_busy, input int stop_at);
    int i, held, start;
    i = 0; held = 0; start = cap_total;
    chk("busy_in_send", {31'd0, BUSY}, 32'd1);
    while (i < NW) begin
      chk($sformatf("word%0d", i), {16'd0, ICAP_I}, {16'd0, vec[i].exp});
      chk($sformatf("strobes%0d", i), {30'd0, ICAP_CE_N, ICAP_WRITE_N}, 32'd0);
      if (i == stop_at) return;
      if (i == NW - 1) chk("done_early", {31'd0, DONE}, 32'd0);
      if (use_busy && held < vec[i].busy_cyc) begin
        ICAP_BUSY = 1'b1;
        held++;
      end else begin
        ICAP_BUSY = 1'b0;
        held = 0;
        i++;
      end
      tick;
    end
    chk("flush_strobes", {30'd0, ICAP_CE_N, ICAP_WRITE_N}, 32'd2);
    chk("flush_done", {31'd0, DONE}, 32'd0);
    tick;
    chk("done_flags", {30'd0, DONE, BUSY}, 32'd2);
    chk("done_strobes", {30'd0, ICAP_CE_N, ICAP_WRITE_N}, 32'd3);
    chk("done_data", {16'd0, ICAP_I}, 32'd0);
    chk("captured", cap_total - start, NW);
  endtask

  initial begin
    int bad, e;
    logic [15:0] exp_tab[NW];
`ifdef ICAP_GOLDEN_FALLBACK_EN
    exp_tab = '{16'hFFFF, 16'h5599, 16'h4C86, 16'h0000, 16'h4C81, 16'hD020,
                16'h4C85, 16'h0000, 16'h4C83, 16'hD080, 16'h0C85, 16'h0070, 16'h0400};
`else
    exp_tab = '{16'hFFFF, 16'h5599, 16'h4C86, 16'h0000, 16'h4C81, 16'hD020,
                16'h0C85, 16'h0070, 16'h0400};
`endif
    for (int i = 0; i < NW; i++) vec[i] = '{(i == 4) ? 3 : 0, exp_tab[i]};

    // Reset state and quiet idle
    @(negedge CLK);
    #1;
    chk("reset_outs", {13'd0, ICAP_CE_N, ICAP_WRITE_N, BUSY, DONE, ICAP_I},
        {13'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000});
    tick;
    RST_N = 1'b1;
    bad = 0;
    repeat (100) begin
      tick;
      if (!ICAP_CE_N || !ICAP_WRITE_N || BUSY || DONE) bad++;
    end
    chk("idle_quiet", bad, 0);

    // Short TRIGGER pulse must not start the stream
    TRIGGER = 1'b1;
    repeat (10) tick;
    TRIGGER = 1'b0;
    bad = 0;
    repeat (40) begin
      tick;
      if (!ICAP_CE_N || !ICAP_WRITE_N) bad++;
    end
    chk("short_pulse_quiet", bad, 0);
    chk("short_pulse_idle", {31'd0, BUSY}, 32'd0);

    // Qualified TRIGGER: latency then full stream without stalls
    TRIGGER = 1'b1;
    wait_ce(e);
    chk("latency", e, 2 + AD + 1);
    run_stream(1'b0, -1);

    // Terminal: re-asserting TRIGGER does nothing
    TRIGGER = 1'b0;
    repeat (5) tick;
    TRIGGER = 1'b1;
    bad = 0;
    repeat (40) begin
      tick;
      if (!ICAP_CE_N || !ICAP_WRITE_N || !DONE || BUSY) bad++;
    end
    chk("terminal", bad, 0);

    // ICAP_BUSY stall on word 4
    do_reset;
    chk("reset_clears_done", {31'd0, DONE}, 32'd0);
    TRIGGER = 1'b1;
    wait_ce(e);
    chk("latency2", e, 2 + AD + 1);
    run_stream(1'b1, -1);

    // Async reset during word 6, then restart from word 0
    do_reset;
    TRIGGER = 1'b1;
    wait_ce(e);
    run_stream(1'b0, 6);
    #1 RST_N = 1'b0;
    #1;
    chk("async_rst_strobes", {30'd0, ICAP_CE_N, ICAP_WRITE_N}, 32'd3);
    chk("async_rst_flags", {30'd0, BUSY, DONE}, 32'd0);
    TRIGGER = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    bad = 0;
    repeat (30) begin
      tick;
      if (!ICAP_CE_N || !ICAP_WRITE_N || DONE) bad++;
    end
    chk("post_rst_quiet", bad, 0);
    TRIGGER = 1'b1;
    wait_ce(e);
    chk("latency3", e, 2 + AD + 1);
    run_stream(1'b0, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
